// File: rtl/imem_loader.sv
// Serial program loader: assembles little-endian bytes into 32-bit words and
// writes them to instruction memory while holding the CPU until the load is done.
module imem_loader #(
    parameter int unsigned DEPTH_LOG2 = 8,
    parameter logic [31:0] START_ADDR = 32'h0000_0000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [15:0] word_count,
    input  logic [7:0]  byte_in,
    input  logic        byte_valid,
    output logic        byte_ready,
    output logic        wr_en,
    output logic [31:0] wr_addr,
    output logic [31:0] wr_data,
    output logic        cpu_hold,
    output logic        done,
    output logic        error
);

    localparam int unsigned CNT_W  = 16;
    localparam int unsigned ADDR_W = 32;
    localparam int unsigned BIDX_W = 2;

    // Largest legal word_count; one bit wider so 2^16 still fits.
    localparam logic [CNT_W:0] MAX_WORDS = (CNT_W + 1)'(64'd1 << DEPTH_LOG2);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] RECV  = 2'd1;
    localparam logic [1:0] WRITE = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    logic [1:0]        state_q, state_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [CNT_W-1:0]  word_idx_q, word_idx_d;
    logic [BIDX_W-1:0] byte_idx_q, byte_idx_d;
    logic [31:0]       word_q, word_d;

    logic              error_d;
    logic              wr_en_d;
    logic [ADDR_W-1:0] wr_addr_d;
    logic [31:0]       wr_data_d;

    logic              start_ok;
    logic              byte_acc;
    logic [CNT_W-1:0]  word_idx_inc;

    // State and datapath registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            count_q    <= '0;
            word_idx_q <= '0;
            byte_idx_q <= '0;
            word_q     <= '0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            word_idx_q <= word_idx_d;
            byte_idx_q <= byte_idx_d;
            word_q     <= word_d;
        end
    end

    // Next-state, datapath and next-output logic.
    always_comb begin
        state_d      = state_q;
        count_d      = count_q;
        word_idx_d   = word_idx_q;
        byte_idx_d   = byte_idx_q;
        word_d       = word_q;
        error_d      = error;
        wr_en_d      = 1'b0;
        wr_addr_d    = wr_addr;
        wr_data_d    = wr_data;
        start_ok     = start && ((state_q == IDLE) || (state_q == DONE));
        byte_acc     = byte_valid && byte_ready;
        word_idx_inc = word_idx_q + CNT_W'(1);

        case (state_q)
            IDLE, DONE: begin
                if (start_ok) begin
                    if (word_count == '0) begin
                        state_d = DONE;
                        error_d = 1'b0;
                    end else if ({1'b0, word_count} > MAX_WORDS) begin
                        state_d = IDLE;
                        error_d = 1'b1;
                    end else begin
                        state_d    = RECV;
                        count_d    = word_count;
                        word_idx_d = '0;
                        byte_idx_d = '0;
                        word_d     = '0;
                        error_d    = 1'b0;
                    end
                end
            end
            RECV: begin
                if (byte_acc) begin
                    word_d[{byte_idx_q, 3'b000} +: 8] = byte_in;
                    byte_idx_d = byte_idx_q + BIDX_W'(1);
                    // Fourth byte completes the word; launch the write next cycle.
                    if (byte_idx_q == BIDX_W'(3)) begin
                        state_d   = WRITE;
                        wr_en_d   = 1'b1;
                        wr_addr_d = START_ADDR + {14'b0, word_idx_q, 2'b00};
                        wr_data_d = {byte_in, word_q[23:0]};
                    end
                end
            end
            WRITE: begin
                word_idx_d = word_idx_inc;
                state_d    = (word_idx_inc == count_q) ? DONE : RECV;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs are registered from the next state so they track the FSM exactly.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            byte_ready <= 1'b0;
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
            cpu_hold   <= 1'b1;
            done       <= 1'b0;
            error      <= 1'b0;
        end else begin
            byte_ready <= (state_d == RECV);
            wr_en      <= wr_en_d;
            wr_addr    <= wr_addr_d;
            wr_data    <= wr_data_d;
            cpu_hold   <= (state_d != DONE);
            done       <= (state_d == DONE);
            error      <= error_d;
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: expected writes are queued as bytes are
// driven and popped by a monitor whenever the loader strobes wr_en.
module tb_imem_loader;

    localparam logic [31:0] START = 32'h0000_0000;

    logic        clock;
    logic        reset;
    logic        start;
    logic [15:0] word_count;
    logic [7:0]  byte_in;
    logic        byte_valid;
    logic        byte_ready;
    logic        wr_en;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;
    logic        cpu_hold;
    logic        done;
    logic        error;

    int checks = 0;
    int errors = 0;
    int writes = 0;
    logic [63:0] sb[$];

    imem_loader #(.DEPTH_LOG2(8), .START_ADDR(START)) dut (
        .clock(clock), .reset(reset), .start(start), .word_count(word_count),
        .byte_in(byte_in), .byte_valid(byte_valid), .byte_ready(byte_ready),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .cpu_hold(cpu_hold), .done(done), .error(error)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Monitor: every write must match the oldest queued expectation.
    always @(negedge clock) begin
        if (wr_en === 1'b1) begin
            writes++;
            if (sb.size() == 0) begin
                chk("unexpected_write", wr_addr, 32'hFFFF_FFFF);
            end else begin
                logic [63:0] e;
                e = sb.pop_front();
                chk("wr_addr", wr_addr, e[63:32]);
                chk("wr_data", wr_data, e[31:0]);
            end
        end
    end

    task automatic tick();
        @(negedge clock);
    endtask

    task automatic do_start(input logic [15:0] n);
        start = 1'b1;
        word_count = n;
        tick();
        start = 1'b0;
    endtask

    // Present a byte with byte_valid high until a handshake edge happens.
    task automatic send_byte(input logic [7:0] b);
        logic r;
        int n;
        byte_in = b;
        byte_valid = 1'b1;
        n = 0;
        do begin
            r = byte_ready;
            tick();
            n++;
        end while (!r && n < 20);
        if (!r) chk("byte_timeout", 32'd0, 32'd1);
    endtask

    task automatic send_word(input logic [31:0] addr, input logic [31:0] w);
        sb.push_back({addr, w});
        for (int i = 0; i < 4; i++) begin
            logic [31:0] t;
            t = w >> (8 * i);
            send_byte(t[7:0]);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_byte_ready"}, 32'(byte_ready), 32'd0);
        chk({tag, "_wr_en"}, 32'(wr_en), 32'd0);
        chk({tag, "_wr_addr"}, wr_addr, 32'd0);
        chk({tag, "_wr_data"}, wr_data, 32'd0);
        chk({tag, "_cpu_hold"}, 32'(cpu_hold), 32'd1);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_error"}, 32'(error), 32'd0);
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        word_count = '0;
        byte_in = '0;
        byte_valid = 1'b0;
        #1;
        chk_reset_vals("por");
        tick();
        reset = 1'b0;
        tick();

        // Two-word load with byte_valid held high.
        do_start(16'd2);
        chk("s1_ready", 32'(byte_ready), 32'd1);
        chk("s1_hold", 32'(cpu_hold), 32'd1);
        send_word(START, 32'h1234_5678);
        send_word(START + 32'd4, 32'hDEAD_BEEF);
        byte_valid = 1'b0;
        chk("s1_latency_wr_en", 32'(wr_en), 32'd1);
        chk("s1_write_ready", 32'(byte_ready), 32'd0);
        chk("s1_not_done_yet", 32'(done), 32'd0);
        tick();
        chk("s1_done", 32'(done), 32'd1);
        chk("s1_hold_low", 32'(cpu_hold), 32'd0);
        chk("s1_wr_en_low", 32'(wr_en), 32'd0);
        chk("s1_addr_hold", wr_addr, START + 32'd4);
        chk("s1_data_hold", wr_data, 32'hDEAD_BEEF);

        // Restart from DONE; byte_valid toggles so only even-cycle bytes count.
        do_start(16'd1);
        chk("s2_hold", 32'(cpu_hold), 32'd1);
        chk("s2_done", 32'(done), 32'd0);
        sb.push_back({START, 32'h1614_1210});
        for (int i = 0; i < 7; i++) begin
            byte_valid = (i % 2 == 0);
            byte_in = 8'h10 + 8'(i);
            tick();
        end
        byte_valid = 1'b0;
        chk("s2_wr_en", 32'(wr_en), 32'd1);
        chk("s2_write_ready", 32'(byte_ready), 32'd0);
        tick();
        chk("s2_done_after", 32'(done), 32'd1);

        // Oversize request is rejected and nothing is written.
        do_start(16'd257);
        chk("s3_error", 32'(error), 32'd1);
        chk("s3_hold", 32'(cpu_hold), 32'd1);
        chk("s3_done", 32'(done), 32'd0);
        byte_valid = 1'b1;
        byte_in = 8'hAA;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("s3_ready_idle", 32'(byte_ready), 32'd0);
        end
        byte_valid = 1'b0;
        chk("s3_error_sticky", 32'(error), 32'd1);
        do_start(16'd1);
        chk("s3_error_cleared", 32'(error), 32'd0);
        send_word(START, 32'hC0FF_EE11);
        byte_valid = 1'b0;
        tick();
        chk("s3_done_after", 32'(done), 32'd1);

        // Rejection from DONE, then a zero-length start.
        do_start(16'd300);
        chk("s4_error", 32'(error), 32'd1);
        chk("s4_hold", 32'(cpu_hold), 32'd1);
        do_start(16'd0);
        chk("s4_done", 32'(done), 32'd1);
        chk("s4_hold_low", 32'(cpu_hold), 32'd0);
        chk("s4_error_cleared", 32'(error), 32'd0);
        chk("s4_no_write", 32'(wr_en), 32'd0);

        // Exactly 2^DEPTH_LOG2 words is legal.
        do_start(16'd256);
        chk("s5_ready", 32'(byte_ready), 32'd1);
        chk("s5_error", 32'(error), 32'd0);

        // Reset mid-word of a 3-word load.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        do_start(16'd3);
        send_byte(8'h01);
        send_byte(8'h02);
        reset = 1'b1;
        #1;
        chk_reset_vals("midrst");
        tick();
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("s6_no_accept", 32'(byte_ready), 32'd0);
        end
        byte_valid = 1'b0;
        do_start(16'd1);
        send_word(START, 32'hA5A5_0F0F);
        byte_valid = 1'b0;
        tick();
        chk("s6_done", 32'(done), 32'd1);

        // Start in RECV is ignored; start in DONE reloads.
        do_start(16'd2);
        sb.push_back({START, 32'h4433_2211});
        send_byte(8'h11);
        byte_valid = 1'b0;
        start = 1'b1;
        word_count = 16'd5;
        tick();
        start = 1'b0;
        chk("s7_still_recv", 32'(byte_ready), 32'd1);
        send_byte(8'h22);
        send_byte(8'h33);
        send_byte(8'h44);
        send_word(START + 32'd4, 32'h8877_6655);
        byte_valid = 1'b0;
        tick();
        chk("s7_done", 32'(done), 32'd1);
        do_start(16'd1);
        chk("s7_hold_raised", 32'(cpu_hold), 32'd1);
        chk("s7_done_low", 32'(done), 32'd0);
        send_word(START, 32'hCAFE_F00D);
        byte_valid = 1'b0;
        tick();
        chk("s7_reload_done", 32'(done), 32'd1);

        tick();
        chk("sb_empty", 32'(sb.size()), 32'd0);
        chk("write_count", 32'(writes), 32'd8);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 The module SHALL have parameter DEPTH_LOG2, default 8, meaning log2 of instruction-memory depth in 32-bit words.
REQ-002 The module SHALL have parameter START_ADDR, default 32'h0000_0000, meaning the byte address of the first word written; it is word-aligned.
REQ-003 Port clock  input  1  single clock; all state changes on its rising edge.
REQ-004 Port reset  input  1  asynchronous, active-high reset.
REQ-005 Port start  input  1  one-cycle request to begin a program load.
REQ-006 Port word_count  input  16  number of words to load; sampled only on an accepted start.
REQ-007 Port byte_in  input  8  incoming program byte.
REQ-008 Port byte_valid  input  1  byte_in holds a valid byte.
REQ-009 Port byte_ready  output  1  loader can accept a byte this cycle.
REQ-010 Port wr_en  output  1  instruction-memory write strobe.
REQ-011 Port wr_addr  output  32  byte address of the write; always word-aligned.
REQ-012 Port wr_data  output  32  word being written.
REQ-013 Port cpu_hold  output  1  holds the processor's PC/reset while memory is not loaded.
REQ-014 Port done  output  1  a load completed successfully.
REQ-015 Port error  output  1  the last start was rejected.

Function
REQ-016 The FSM SHALL have states IDLE, RECV, WRITE and DONE.
REQ-017 A byte SHALL be accepted only in a cycle where byte_valid=1 and byte_ready=1.
REQ-018 byte_ready SHALL be 1 only in RECV.
REQ-019 Bytes SHALL be assembled little-endian: 1st accepted byte to [7:0], 2nd to [15:8], 3rd to [23:16], 4th to [31:24].
REQ-020 start SHALL be accepted only in IDLE or DONE; start in RECV or WRITE SHALL be ignored.
REQ-021 On an accepted start with word_count=0, the FSM SHALL go to DONE and clear error.
REQ-022 On an accepted start with word_count > 2^DEPTH_LOG2, the FSM SHALL go to IDLE, set error=1, and write nothing.
REQ-023 On any other accepted start, the FSM SHALL:
- latch word_count;
- clear word index, byte index and error;
- go to RECV.
REQ-024 In RECV, accepting the 4th byte of a word SHALL move the FSM to WRITE on the next edge.
REQ-025 WRITE SHALL last exactly one cycle with wr_en=1, wr_data=assembled word and wr_addr=START_ADDR+4*word_index.
REQ-026 Address arithmetic SHALL be 32-bit modulo 2^32.
REQ-027 After WRITE, word_index SHALL increment; if the new index equals the latched count the FSM SHALL go to DONE, otherwise to RECV.
REQ-028 wr_en SHALL be 0 outside WRITE; wr_addr and wr_data SHALL hold their last values when wr_en=0.
REQ-029 cpu_hold SHALL be 0 only in DONE.
REQ-030 An accepted start from DONE SHALL make cpu_hold=1 and done=0 from the next cycle.
REQ-031 done SHALL be 1 only in DONE.
REQ-032 error SHALL stay set until the next accepted start that is not rejected.
REQ-033 Write latency SHALL be one cycle: the 4th byte accepted at edge N gives wr_en=1 in the cycle after edge N.
REQ-034 Minimum spacing SHALL be 5 cycles per word, because byte_ready=0 during WRITE.

Reset
REQ-035 While reset=1 the module SHALL be in IDLE, asynchronously, with outputs:
- byte_ready=0, wr_en=0, wr_addr=0, wr_data=0;
- cpu_hold=1, done=0, error=0.
REQ-036 Reset asserted mid-load SHALL discard any partial word and the word index, and SHALL issue no further writes.
REQ-037 After reset release the module SHALL need a new start to load.

Verification
REQ-038 Scenario: START_ADDR=0, start with word_count=2, then bytes 78,56,34,12,EF,BE,AD,DE with byte_valid held high.
- Response: write 0x12345678 at address 0x0, then 0xDEADBEEF at address 0x4.
- Response: done=1 and cpu_hold=0 the cycle after the second write.
REQ-039 Scenario: byte_valid toggled 1/0 each cycle during a 1-word load.
- Response: only handshaked bytes are assembled.
- Response: exactly one write.
- Response: byte_ready=0 during the WRITE cycle.
REQ-040 Scenario: DEPTH_LOG2=8, start with word_count=257.
- Response: error=1, no wr_en, and the FSM stays in IDLE.
- Response: a following start with word_count=1 clears error and the load completes.
REQ-041 Scenario: start with word_count=0.
- Response: done=1 and cpu_hold=0 after one edge, with no write.
REQ-042 Scenario: reset pulsed after 2 bytes of word 1 of a 3-word load.
- Response: outputs return to their reset values immediately.
- Response: no write occurs; a new start then loads from START_ADDR.
REQ-043 Scenario: start pulsed in RECV, then start pulsed in DONE.
- Response: the first start is ignored.
- Response: the second start raises cpu_hold the next cycle and a reload begins at START_ADDR.
